// File: rtl/ha_array_accum_pipe.sv
// Three-stage valid/ready accumulator that weights the four HA-array row pairs
// into a 16-bit product, with optional saturation and a handshake counter.
module ha_array_accum_pipe #(
  parameter int unsigned COUNT_W  = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         ha_array_0_b,
  input  logic [8:0]         ha_array_0_t,
  input  logic [6:0]         ha_array_1_b,
  input  logic [8:0]         ha_array_1_t,
  input  logic [6:0]         ha_array_2_b,
  input  logic [8:0]         ha_array_2_t,
  input  logic [6:0]         ha_array_3_b,
  input  logic [8:0]         ha_array_3_t,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        product,
  output logic               ovf,
  output logic [COUNT_W-1:0] txn_cnt
);

  logic [3:0][6:0]  row_b;
  logic [3:0][8:0]  row_t;
  logic [3:0][9:0]  r_d;
  logic [3:0][9:0]  r_q;
  logic [12:0]      p0_d;
  logic [12:0]      p1_d;
  logic [12:0]      p0_q;
  logic [12:0]      p1_q;
  logic [16:0]      s_d;
  logic             v1;
  logic             v2;
  logic             v3;
  logic             ld1;
  logic             ld2;
  logic             ld3;

  assign row_b = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
  assign row_t = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};

  // A stage may load when empty or when the stage ahead is draining it.
  assign ld3      = !v3 || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;
  assign out_valid = v3;

  always_comb begin
    r_d = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      r_d[k] = {1'b0, row_t[k]} + {1'b0, row_b[k], 2'b00};
    end
  end

  assign p0_d = {3'b000, r_q[0]} + {1'b0, r_q[1], 2'b00};
  assign p1_d = {3'b000, r_q[2]} + {1'b0, r_q[3], 2'b00};
  assign s_d  = {4'b0000, p0_q} + {p1_q, 4'b0000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      r_q <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        r_q <= r_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      p0_q <= '0;
      p1_q <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        p0_q <= p0_d;
        p1_q <= p1_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3      <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        product <= (SATURATE && s_d[16]) ? 16'hFFFF : s_d[15:0];
        ovf     <= s_d[16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (v3 && out_ready) begin
      txn_cnt <= txn_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ha_array_accum_pipe.sv
// Directed bench for ha_array_accum_pipe: a transaction-level queue model checks
// three parameterisations every cycle, with literal expectations tagged on beats.
module tb_ha_array_accum_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [6:0]  b0 = '0, b1 = '0, b2 = '0, b3 = '0;
  logic [8:0]  t0 = '0, t1 = '0, t2 = '0, t3 = '0;

  logic        in_ready_a, out_valid_a, ovf_a;
  logic [15:0] product_a, txn_a;
  logic        in_ready_n, out_valid_n, ovf_n;
  logic [15:0] product_n, txn_n;
  logic        in_ready_c, out_valid_c, ovf_c;
  logic [15:0] product_c;
  logic [1:0]  txn_c;

  always #5 clk = ~clk;

  ha_array_accum_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .ha_array_0_b(b0), .ha_array_0_t(t0), .ha_array_1_b(b1), .ha_array_1_t(t1),
    .ha_array_2_b(b2), .ha_array_2_t(t2), .ha_array_3_b(b3), .ha_array_3_t(t3),
    .out_valid(out_valid_a), .out_ready(out_ready), .product(product_a),
    .ovf(ovf_a), .txn_cnt(txn_a)
  );

  ha_array_accum_pipe #(.SATURATE(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .ha_array_0_b(b0), .ha_array_0_t(t0), .ha_array_1_b(b1), .ha_array_1_t(t1),
    .ha_array_2_b(b2), .ha_array_2_t(t2), .ha_array_3_b(b3), .ha_array_3_t(t3),
    .out_valid(out_valid_n), .out_ready(out_ready), .product(product_n),
    .ovf(ovf_n), .txn_cnt(txn_n)
  );

  ha_array_accum_pipe #(.COUNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .ha_array_0_b(b0), .ha_array_0_t(t0), .ha_array_1_b(b1), .ha_array_1_t(t1),
    .ha_array_2_b(b2), .ha_array_2_t(t2), .ha_array_3_b(b3), .ha_array_3_t(t3),
    .out_valid(out_valid_c), .out_ready(out_ready), .product(product_c),
    .ovf(ovf_c), .txn_cnt(txn_c)
  );

  typedef struct {
    logic [3:0][6:0] b;
    logic [3:0][8:0] t;
    bit              le;
    int unsigned     lit;
    int unsigned     lit_ns;
  } item_t;

  typedef struct {
    int unsigned s;
    int unsigned age;
    bit          le;
    int unsigned lit;
    int unsigned lit_ns;
  } ent_t;

  item_t       items [1024];
  bit          cur_le = 1'b0;
  int unsigned cur_lit = 0, cur_lit_ns = 0;
  bit          final_chk = 1'b0;
  bit          chk_done = 1'b0;
  int unsigned n_vec = 0, n_err = 0;

  // Every bit contributes its positional weight; no staging.
  function automatic int unsigned ref_sum(input logic [3:0][6:0] b, input logic [3:0][8:0] t);
    int unsigned s = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      s += (32'(t[k]) << (2 * k)) + (32'(b[k]) << (2 * k + 2));
    end
    return s;
  endfunction

  // Exact HA array over partial-product rows 2k and 2k+1 of x*y.
  task automatic ha_rows(input logic [7:0] x, input logic [7:0] y,
                         output logic [3:0][6:0] b, output logic [3:0][8:0] t);
    logic [7:0] a, c;
    b = '0;
    t = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      a = x & {8{y[2 * k]}};
      c = x & {8{y[2 * k + 1]}};
      t[k][0] = a[0];
      for (int unsigned j = 1; j < 8; j++) begin
        t[k][j]     = a[j] ^ c[j - 1];
        b[k][j - 1] = a[j] & c[j - 1];
      end
      t[k][8] = c[7];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", 32'(out_valid_a), 0);
    chk("rst_product",   32'(product_a), 0);
    chk("rst_ovf",       32'(ovf_a), 0);
    chk("rst_txn",       32'(txn_a), 0);
    chk("rst_out_valid_ns", 32'(out_valid_n), 0);
    chk("rst_product_ns",   32'(product_n), 0);
    chk("rst_txn_c2",       32'(txn_c), 0);
    chk("rst_in_ready",     32'(in_ready_a), 1);
  endtask

  initial begin : model
    ent_t        q[$];
    ent_t        e;
    int unsigned cnt;
    bit          ex_in, ex_out, acc;
    cnt = 0;
    ex_out = 1'b0;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      if (final_chk && !chk_done) begin
        chk("drain_empty", q.size(), 0);
        chk_done = 1'b1;
      end
      if (!rst_n) begin
        chk_reset_outputs();
        ex_out = 1'b0;
        acc = 1'b0;
      end else begin
        ex_out = (q.size() > 0) && (q[0].age >= 3);
        ex_in  = (q.size() < 3) || out_ready;
        chk("in_ready",     32'(in_ready_a), 32'(ex_in));
        chk("in_ready_ns",  32'(in_ready_n), 32'(ex_in));
        chk("in_ready_c2",  32'(in_ready_c), 32'(ex_in));
        chk("out_valid",    32'(out_valid_a), 32'(ex_out));
        chk("out_valid_ns", 32'(out_valid_n), 32'(ex_out));
        chk("out_valid_c2", 32'(out_valid_c), 32'(ex_out));
        if (ex_out) begin
          e = q[0];
          chk("product",    32'(product_a), (e.s > 65535) ? 32'hFFFF : (e.s & 32'hFFFF));
          chk("product_ns", 32'(product_n), e.s & 32'hFFFF);
          chk("product_c2", 32'(product_c), (e.s > 65535) ? 32'hFFFF : (e.s & 32'hFFFF));
          chk("ovf",        32'(ovf_a), 32'(e.s > 65535));
          chk("ovf_ns",     32'(ovf_n), 32'(e.s > 65535));
          if (e.le) begin
            chk("lit_product",    32'(product_a), e.lit);
            chk("lit_product_ns", 32'(product_n), e.lit_ns);
          end
        end
        chk("txn_cnt",    32'(txn_a), cnt & 32'hFFFF);
        chk("txn_cnt_c2", 32'(txn_c), cnt & 32'h3);
        acc = in_valid && ex_in;
        e.s      = ref_sum({b3, b2, b1, b0}, {t3, t2, t1, t0});
        e.age    = 0;
        e.le     = cur_le;
        e.lit    = cur_lit;
        e.lit_ns = cur_lit_ns;
      end
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        cnt = 0;
        #1;
        chk_reset_outputs();
      end else begin
        if (ex_out && out_ready) begin
          void'(q.pop_front());
          cnt++;
        end
        if (acc) q.push_back(e);
        for (int i = 0; i < q.size(); i++) q[i].age++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int unsigned i);
    {b3, b2, b1, b0} = items[i].b;
    {t3, t2, t1, t0} = items[i].t;
    cur_le     = items[i].le;
    cur_lit    = items[i].lit;
    cur_lit_ns = items[i].lit_ns;
  endtask

  task automatic clear_items(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      items[i].b = '0;
      items[i].t = '0;
      items[i].le = 1'b0;
      items[i].lit = 0;
      items[i].lit_ns = 0;
    end
  endtask

  // Present n items back to back; out_ready is low for cycles s_lo..s_hi.
  task automatic stream(input int unsigned n, input int unsigned s_lo, input int unsigned s_hi);
    int unsigned idx = 0;
    int unsigned c = 0;
    logic a;
    while (idx < n && c < 5000) begin
      out_ready = !(c >= s_lo && c <= s_hi);
      apply(idx);
      in_valid = 1'b1;
      @(negedge clk);
      a = in_ready_a;
      step();
      if (a) idx++;
      c++;
    end
    in_valid  = 1'b0;
    cur_le    = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0][6:0] rb;
    logic [3:0][8:0] rt;
    logic [7:0] xs [3];
    logic [7:0] x, y;
    int unsigned n;
    xs[0] = 8'd0; xs[1] = 8'd1; xs[2] = 8'd255;

    #2 rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    clear_items(4);
    items[0].t[0] = 9'h001;
    items[0].le = 1'b1; items[0].lit = 1; items[0].lit_ns = 1;
    stream(1, 1000, 0);

    clear_items(4);
    items[0].b[3][6] = 1'b1; items[0].t[3][8] = 1'b1;
    items[0].le = 1'b1; items[0].lit = 32'h8000; items[0].lit_ns = 32'h8000;
    items[1].b[2][0] = 1'b1;
    items[1].le = 1'b1; items[1].lit = 32'h0040; items[1].lit_ns = 32'h0040;
    stream(2, 1000, 0);

    clear_items(4);
    items[0].b = '1; items[0].t = '1;
    items[0].le = 1'b1; items[0].lit = 32'hFFFF; items[0].lit_ns = 32'h5257;
    stream(1, 1000, 0);

    n = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        ha_rows(xs[i], xs[j], rb, rt);
        items[n].b = rb; items[n].t = rt; items[n].le = 1'b1;
        items[n].lit = 32'(xs[i]) * 32'(xs[j]); items[n].lit_ns = items[n].lit;
        n++;
      end
    end
    for (int unsigned i = 0; i < 1000; i++) begin
      x = 8'($urandom_range(255, 0));
      y = 8'($urandom_range(255, 0));
      ha_rows(x, y, rb, rt);
      items[n].b = rb; items[n].t = rt; items[n].le = 1'b1;
      items[n].lit = 32'(x) * 32'(y); items[n].lit_ns = items[n].lit;
      n++;
    end
    stream(n, 1000, 0);

    clear_items(10);
    for (int unsigned i = 0; i < 10; i++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        items[i].t[k] = 9'(i * 37 + k * 11 + 1);
        items[i].b[k] = 7'(i * 5 + k);
      end
    end
    stream(10, 2, 8);

    clear_items(5);
    for (int unsigned i = 0; i < 5; i++) items[i].t[1] = 9'(i + 3);
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      apply(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    clear_items(5);
    for (int unsigned i = 0; i < 5; i++) begin
      items[i].t[0] = 9'(i + 1);
      items[i].le = 1'b1; items[i].lit = i + 1; items[i].lit_ns = i + 1;
    end
    stream(5, 1000, 0);

    final_chk = 1'b1;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
